// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiply sequencer.
// The MULT_RUN_SYNC_EN build option is resolved in mult_sequencer, not here.
package mult_pkg;

    localparam int MULT_WIDTH = 8;
    localparam int ITER_W     = $clog2(MULT_WIDTH);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MULT_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR_LD = 3'd1,
        ST_START  = 3'd2,
        ST_EVAL   = 3'd3,
        ST_ADD    = 3'd4,
        ST_SUB    = 3'd5,
        ST_SHIFT  = 3'd6,
        ST_HALT   = 3'd7
    } mult_state_t;

    // Busy covers the whole multiply, START through the last SHIFT.
    function automatic logic state_busy(input mult_state_t s);
        return (s == ST_START) || (s == ST_EVAL) || (s == ST_ADD) ||
               (s == ST_SUB)   || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single-bit level input; clears to 0 on reset.
module sync2 (
    input  logic Clk,
    input  logic Reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for an 8-bit signed add-shift multiplier; Moore-decoded datapath strobes.
// Build option MULT_RUN_SYNC_EN: pass Run and Load through two-flop synchronizers.
module mult_sequencer
    import mult_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Run,
    input  logic              Load,
    input  logic              M,
    output logic              Clr_Ld,
    output logic              Clr_XA,
    output logic              Add,
    output logic              Sub,
    output logic              Shift,
    output logic              Busy,
    output logic              Done,
    output logic [ITER_W-1:0] Iter
);

    logic run_s;
    logic load_s;

`ifdef MULT_RUN_SYNC_EN
    sync2 u_sync_run  (.Clk(Clk), .Reset_n(Reset_n), .d(Run),  .q(run_s));
    sync2 u_sync_load (.Clk(Clk), .Reset_n(Reset_n), .d(Load), .q(load_s));
`else
    assign run_s  = Run;
    assign load_s = Load;
`endif

    mult_state_t       state, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              run_q;
    logic              run_edge;

    // run_q resets high so a Run held through reset release is not an edge.
    assign run_edge = run_s & ~run_q;

    always_comb begin
        state_d = state;
        iter_d  = iter_q;
        unique case (state)
            ST_IDLE: begin
                if (load_s) begin
                    state_d = ST_CLR_LD;
                end else if (run_edge) begin
                    state_d = ST_START;
                    iter_d  = '0;
                end
            end
            ST_CLR_LD: state_d = ST_IDLE;
            ST_START: begin
                state_d = ST_EVAL;
                iter_d  = '0;
            end
            ST_EVAL: begin
                if (!M)                    state_d = ST_SHIFT;
                else if (iter_q == LAST_ITER) state_d = ST_SUB;
                else                       state_d = ST_ADD;
            end
            ST_ADD:   state_d = ST_SHIFT;
            ST_SUB:   state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (iter_q == LAST_ITER) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EVAL;
                    iter_d  = iter_q + ITER_W'(1);
                end
            end
            ST_HALT: if (!run_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= ST_IDLE;
            iter_q <= '0;
            run_q  <= 1'b1;
        end else begin
            state  <= state_d;
            iter_q <= iter_d;
            run_q  <= run_s;
        end
    end

    // Strobes depend on state alone, so reset clears them without a register stage.
    assign Clr_Ld = (state == ST_CLR_LD);
    assign Clr_XA = (state == ST_START);
    assign Add    = (state == ST_ADD);
    assign Sub    = (state == ST_SUB);
    assign Shift  = (state == ST_SHIFT);
    assign Busy   = state_busy(state);
    assign Done   = (state == ST_HALT);
    assign Iter   = iter_q;

endmodule
